// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage memory access unit.
// State encodings and the default RAM timeout live here.
package mem_access_unit_pkg;

    localparam int MAS_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        MAS_IDLE = 2'd0,
        MAS_BUSY = 2'd1,
        MAS_DONE = 2'd2
    } mas_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Datapath data-memory port plus the cs/ack word-RAM bus.
// master = the access unit, slave = datapath/RAM side.
interface mem_access_unit_if;

    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        mem_err;

    logic        ram_cs;
    logic        ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;

    modport master (
        input  mem_ren, mem_wen, mem_addr, mem_dout,
        input  ram_rdata, ram_ack,
        output mem_din, mem_stall, mem_err,
        output ram_cs, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output mem_ren, mem_wen, mem_addr, mem_dout,
        output ram_rdata, ram_ack,
        input  mem_din, mem_stall, mem_err,
        input  ram_cs, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage bridge to a variable-latency word RAM (cs/ack).
// Stalls the pipeline while a RAM access is outstanding.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = MAS_TIMEOUT_DEF,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.master bus
);

    mas_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      din_q, din_nxt;
    logic             err_q, err_nxt;
    logic             cs_q, cs_nxt;
    logic             we_q, we_nxt;
    logic [29:0]      addr_q, addr_nxt;
    logic [31:0]      wdata_q, wdata_nxt;
    logic             req;
    logic             aligned;

    assign req     = bus.mem_ren | bus.mem_wen;
    assign aligned = (bus.mem_addr[1:0] == 2'b00);

    // State and registered outputs; reset aborts any access at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MAS_IDLE;
            cnt     <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            din_q   <= din_nxt;
            err_q   <= err_nxt;
            cs_q    <= cs_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
        end
    end

    // Next state; we_q doubles as the latched write flag while BUSY.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        din_nxt   = din_q;
        err_nxt   = err_q;
        cs_nxt    = cs_q;
        we_nxt    = we_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        unique case (state)
            MAS_IDLE: begin
                if (req && aligned) begin
                    addr_nxt  = bus.mem_addr[31:2];
                    wdata_nxt = bus.mem_dout;
                    we_nxt    = bus.mem_wen;
                    cs_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = MAS_BUSY;
                end else if (req) begin
                    err_nxt   = 1'b1;
                    din_nxt   = '0;
                    state_nxt = MAS_DONE;
                end
            end
            MAS_BUSY: begin
                if (bus.ram_ack) begin
                    if (!we_q) din_nxt = bus.ram_rdata;
                    cs_nxt    = 1'b0;
                    we_nxt    = 1'b0;
                    state_nxt = MAS_DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    cs_nxt    = 1'b0;
                    err_nxt   = 1'b1;
                    din_nxt   = '0;
                    state_nxt = MAS_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            MAS_DONE: state_nxt = MAS_IDLE;
            default:  state_nxt = MAS_IDLE;
        endcase
    end

    // Stall from the request cycle until the access reaches DONE.
    assign bus.mem_stall = ((state == MAS_IDLE) && req && aligned)
                         || (state == MAS_BUSY);

    assign bus.mem_din   = din_q;
    assign bus.mem_err   = err_q;
    assign bus.ram_cs    = cs_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with a transaction-level
// reference model and a per-cycle compare process.
module tb_mem_access_unit;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    bit          chk_en   = 1'b0;
    int          stall_cnt;
    int          we_cnt;
    int          cs_cnt;

    logic        exp_stall;
    logic        m_err;
    logic        m_cs;
    logic        m_we;
    logic [31:0] m_din;
    logic [31:0] m_wdata;
    logic [29:0] m_addr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_stall", 32'(bus.mem_stall), 32'(exp_stall));
            chk("mem_din", bus.mem_din, m_din);
            chk("mem_err", 32'(bus.mem_err), 32'(m_err));
            chk("ram_cs", 32'(bus.ram_cs), 32'(m_cs));
            chk("ram_we", 32'(bus.ram_we), 32'(m_we));
            chk("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
            chk("ram_wdata", bus.ram_wdata, m_wdata);
            if (bus.mem_stall) stall_cnt++;
            if (bus.ram_cs && bus.ram_we) we_cnt++;
            if (bus.ram_cs) cs_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_err   = 1'b0;
        m_cs    = 1'b0;
        m_we    = 1'b0;
        m_din   = '0;
        m_wdata = '0;
        m_addr  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            bus.mem_ren   = 1'b0;
            bus.mem_wen   = 1'b0;
            bus.mem_addr  = $urandom;
            bus.mem_dout  = $urandom;
            bus.ram_ack   = 1'($urandom_range(0, 1));
            bus.ram_rdata = $urandom;
            exp_stall     = 1'b0;
        end
    endtask

    task automatic do_reset();
        step();
        rst         = 1'b1;
        bus.mem_ren = 1'b0;
        bus.mem_wen = 1'b0;
        bus.ram_ack = 1'b0;
        model_reset();
        exp_stall   = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // One datapath access; ack_at > TO means the RAM never answers.
    // Returns right after driving the DONE (or error) cycle.
    task automatic access(input bit ren, input bit wen,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rdv, input int ack_at,
                          input bit hold);
        bit al;
        bit acked;
        int k;
        al    = (a[1:0] == 2'b00);
        acked = (ack_at <= TO);
        k     = acked ? ack_at : TO;
        step();
        bus.mem_ren   = ren;
        bus.mem_wen   = wen;
        bus.mem_addr  = a;
        bus.mem_dout  = d;
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = $urandom;
        exp_stall     = al;
        if (!al) begin
            step();
            if (!hold) begin
                bus.mem_ren = 1'b0;
                bus.mem_wen = 1'b0;
            end
            bus.ram_ack = 1'($urandom_range(0, 1));
            m_err       = 1'b1;
            m_din       = '0;
            exp_stall   = 1'b0;
            return;
        end
        for (int i = 1; i <= k; i++) begin
            step();
            m_cs          = 1'b1;
            m_we          = wen;
            m_addr        = a[31:2];
            m_wdata       = d;
            bus.ram_ack   = acked && (i == k);
            bus.ram_rdata = bus.ram_ack ? rdv : $urandom;
            exp_stall     = 1'b1;
        end
        step();
        m_cs = 1'b0;
        if (acked) begin
            m_we = 1'b0;
            if (!wen) m_din = rdv;
        end else begin
            m_err = 1'b1;
            m_din = '0;
        end
        exp_stall = 1'b0;
        if (!hold) begin
            bus.mem_ren = 1'b0;
            bus.mem_wen = 1'b0;
        end
        bus.ram_ack   = 1'($urandom_range(0, 1));
        bus.ram_rdata = $urandom;
    endtask

    initial begin
        int          r;
        logic [31:0] a;
        int          ack_at;
        rst           = 1'b1;
        bus.mem_ren   = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_dout  = '0;
        bus.ram_rdata = '0;
        bus.ram_ack   = 1'b0;
        model_reset();
        exp_stall = 1'b0;
        stall_cnt = 0;
        we_cnt    = 0;
        cs_cnt    = 0;
        chk_en    = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        stall_cnt = 0;
        access(1, 0, 32'h10, 32'h0, 32'hCAFE_0001, 1, 0);
        chk("rd0_din", bus.mem_din, 32'hCAFE_0001);
        chk("rd0_addr", 32'(bus.ram_addr), 32'h4);
        chk("rd0_err", 32'(bus.mem_err), 32'h0);
        chk("rd0_stall_cycles", stall_cnt, 2);

        stall_cnt = 0;
        we_cnt    = 0;
        access(0, 1, 32'h100, 32'h1234_5678, 32'h0, 4, 0);
        chk("wr3_stall_cycles", stall_cnt, 5);
        chk("wr3_we_cycles", we_cnt, 4);
        chk("wr3_wdata", bus.ram_wdata, 32'h1234_5678);
        chk("wr3_din", bus.mem_din, 32'hCAFE_0001);

        idle(1);
        stall_cnt = 0;
        cs_cnt    = 0;
        access(1, 0, 32'h13, 32'h0, 32'h0, 1, 0);
        chk("mis_err", 32'(bus.mem_err), 32'h1);
        chk("mis_din", bus.mem_din, 32'h0);
        idle(1);
        chk("mis_stall_cycles", stall_cnt, 0);
        chk("mis_cs_cycles", cs_cnt, 0);

        do_reset();
        stall_cnt = 0;
        access(1, 0, 32'h40, 32'h0, 32'h0, TO + 1, 0);
        chk("to_stall_cycles", stall_cnt, TO + 1);
        chk("to_err", 32'(bus.mem_err), 32'h1);
        chk("to_din", bus.mem_din, 32'h0);
        chk("to_cs", 32'(bus.ram_cs), 32'h0);
        access(1, 0, 32'h44, 32'h0, 32'hBEEF_0002, 2, 0);
        chk("post_to_din", bus.mem_din, 32'hBEEF_0002);
        chk("post_to_err", 32'(bus.mem_err), 32'h1);

        access(1, 0, 32'h48, 32'h0, 32'h0DD0_0003, TO, 0);
        chk("ack_last_din", bus.mem_din, 32'h0DD0_0003);

        step();
        bus.mem_ren  = 1'b1;
        bus.mem_wen  = 1'b0;
        bus.mem_addr = 32'h20;
        bus.ram_ack  = 1'b0;
        exp_stall    = 1'b1;
        step();
        m_cs   = 1'b1;
        m_we   = 1'b0;
        m_addr = 30'h8;
        step();
        #2;
        chk_en      = 1'b0;
        rst         = 1'b1;
        bus.mem_ren = 1'b0;
        #1;
        chk("rst_cs", 32'(bus.ram_cs), 32'h0);
        chk("rst_stall", 32'(bus.mem_stall), 32'h0);
        chk("rst_err", 32'(bus.mem_err), 32'h0);
        model_reset();
        exp_stall = 1'b0;
        step();
        rst         = 1'b0;
        bus.ram_ack = 1'b1;
        chk_en      = 1'b1;
        step();
        bus.ram_ack = 1'b0;
        access(1, 0, 32'h24, 32'h0, 32'h5A5A_0004, 1, 0);
        chk("post_rst_din", bus.mem_din, 32'h5A5A_0004);

        stall_cnt = 0;
        access(1, 0, 32'h200, 32'h0, 32'hAAAA_0005, 1, 1);
        access(1, 0, 32'h204, 32'h0, 32'hBBBB_0006, 1, 0);
        chk("b2b_stall_cycles", stall_cnt, 4);
        chk("b2b_din", bus.mem_din, 32'hBBBB_0006);

        we_cnt = 0;
        access(1, 1, 32'h300, 32'h7777_0007, 32'h0, 1, 0);
        chk("both_we_cycles", we_cnt, 1);
        chk("both_din", bus.mem_din, 32'hBBBB_0006);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(1, 3);
            a = $urandom;
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            case ($urandom_range(0, 14))
                0:       ack_at = TO + 1;
                1:       ack_at = TO;
                default: ack_at = $urandom_range(1, 6);
            endcase
            access(r[0], r[1], a, $urandom, $urandom, ack_at,
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        idle(2);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
